// File: rtl/hex_to_dec.sv
// hex_to_dec: 8-bit unsigned binary to 3-digit BCD converter for the FND path.
// The conversion is a combinational shift-and-add-3 (double dabble) network,
// unrolled over 8 iterations, followed by one register stage. Latency is one
// clock, and a new value is accepted on every cycle.
module hex_to_dec (
   input  logic       iCLK,
   input  logic       iRSTn,
   input  logic [7:0] iDAT,
   output logic [1:0] oHun,
   output logic [3:0] oTen,
   output logic [3:0] oOne
);

   // Double dabble over a 10-bit BCD field {hundreds[1:0], tens[3:0], ones[3:0]}.
   // Before each shift, any 4-bit nibble holding 5 or more gets 3 added to it.
   // This makes the next shift carry correctly into the next decimal digit.
   // The hundreds field is only 2 bits wide and never reaches 5 for 8-bit
   // inputs, so it needs no correction.
   function automatic logic [9:0] f_dabble(input logic [7:0] bin);
      logic [9:0] bcd;
      bcd = '0;
      for (int i = 7; i >= 0; i--) begin
         if (bcd[3:0] >= 4'd5) bcd[3:0] = bcd[3:0] + 4'd3;
         if (bcd[7:4] >= 4'd5) bcd[7:4] = bcd[7:4] + 4'd3;
         bcd = {bcd[8:0], bin[i]};
      end
      return bcd;
   endfunction

   logic [9:0] w_bcd;

   // Combinational conversion of the current input value.
   always_comb begin
      w_bcd = f_dabble(iDAT);
   end

   // Output register: cleared asynchronously by reset, otherwise loads the
   // conversion result on every rising edge.
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         oHun <= 2'd0;
         oTen <= 4'd0;
         oOne <= 4'd0;
      end else begin
         oHun <= w_bcd[9:8];
         oTen <= w_bcd[7:4];
         oOne <= w_bcd[3:0];
      end
   end

endmodule

// File: tb/tb_hex_to_dec.sv
// tb_hex_to_dec: directed and exhaustive test of hex_to_dec. Each expected
// result is queued when its input is driven and is compared one edge later.
module tb_hex_to_dec;

   logic       iCLK = 1'b0;
   logic       iRSTn;
   logic [7:0] iDAT;
   logic [1:0] oHun;
   logic [3:0] oTen;
   logic [3:0] oOne;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [9:0] q_exp[$];
   logic [9:0] w_out;

   hex_to_dec dut (
      .iCLK  (iCLK),
      .iRSTn (iRSTn),
      .iDAT  (iDAT),
      .oHun  (oHun),
      .oTen  (oTen),
      .oOne  (oOne)
   );

   always #5 iCLK = ~iCLK;

   assign w_out = {oHun, oTen, oOne};

   // Reference model: digits obtained by plain division and remainder.
   function automatic logic [9:0] ref_bcd(input int d);
      logic [1:0] h;
      logic [3:0] t;
      logic [3:0] o;
      h = 2'(d / 100);
      t = 4'((d / 10) % 10);
      o = 4'(d % 10);
      return {h, t, o};
   endfunction

   task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d/%0d/%0d expected %0d/%0d/%0d",
                tag, obs[9:8], obs[7:4], obs[3:0], exp[9:8], exp[7:4], exp[3:0]);
      end
   endtask

   task automatic check_pop(input string tag);
      logic [9:0] exp;
      if (q_exp.size() == 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL %s: observed %0h expected <queue empty>", tag, w_out);
      end else begin
         exp = q_exp.pop_front();
         check(tag, w_out, exp);
      end
   endtask

   // Drive one value on the falling edge and check its result just after the
   // next rising edge.
   task automatic apply(input logic [7:0] d, input string tag);
      @(negedge iCLK);
      iDAT = d;
      q_exp.push_back(ref_bcd(int'(d)));
      @(posedge iCLK);
      #1;
      check_pop(tag);
   endtask

   initial begin
      iRSTn = 1'b1;
      iDAT  = 8'h55;

      // Asynchronous reset, asserted before the first clock edge.
      #1 iRSTn = 1'b0;
      #2 check("rst_async", w_out, 10'd0);
      @(posedge iCLK);
      #1 check("rst_hold", w_out, 10'd0);
      @(negedge iCLK);
      check("rst_hold_neg", w_out, 10'd0);
      iRSTn = 1'b1;
      q_exp.push_back(ref_bcd(8'h55));
      @(posedge iCLK);
      #1 check_pop("rst_release_55");

      // Small values.
      apply(8'h00, "small_00");
      apply(8'h09, "small_09");
      apply(8'h0A, "small_0A");

      // Latency: output must hold until the next edge after an input change.
      @(negedge iCLK);
      iDAT = 8'h63;
      #1 check("latency_hold", w_out, ref_bcd(8'h0A));
      q_exp.push_back(ref_bcd(8'h63));
      @(posedge iCLK);
      #1 check_pop("latency_63");

      // Mid-range values.
      apply(8'h1F, "mid_1F");
      apply(8'h32, "mid_32");
      apply(8'h63, "mid_63");

      // Hundreds boundary.
      apply(8'h64, "hun_64");
      apply(8'hC7, "hun_C7");
      apply(8'hC8, "hun_C8");
      apply(8'hFF, "hun_FF");

      // Back-to-back streaming on consecutive cycles.
      apply(8'h0A, "stream_0A");
      apply(8'h1F, "stream_1F");
      apply(8'h64, "stream_64");
      apply(8'hFF, "stream_FF");

      // Exhaustive sweep with digit range checks and one mid-sweep reset.
      for (int v = 0; v < 256; v++) begin
         apply(8'(v), "sweep");
         check("ten_range", 10'(oTen <= 4'd9), 10'd1);
         check("one_range", 10'(oOne <= 4'd9), 10'd1);
         check("hun_range", 10'(oHun <= 2'd2), 10'd1);
         if (v == 150) begin
            #2 iRSTn = 1'b0;
            #1 check("sweep_rst_async", w_out, 10'd0);
            q_exp.delete();
            @(posedge iCLK);
            #1 check("sweep_rst_hold", w_out, 10'd0);
            @(negedge iCLK);
            iRSTn = 1'b1;
            q_exp.push_back(ref_bcd(v));
            @(posedge iCLK);
            #1 check_pop("sweep_rst_release");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
